// File: rtl/mdu_pipelined_pkg.sv
// Shared op codes and FSM state encoding for the multiply/divide unit.
// Build option: define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_pipelined_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MTHI  = 4'd4;
  localparam logic [3:0] MDU_MTLO  = 4'd5;
  // Accumulate codes exist in every build; they decode only when MDU_MADD_EN is defined.
  localparam logic [3:0] MDU_MADD  = 4'd6;
  localparam logic [3:0] MDU_MADDU = 4'd7;
  localparam logic [3:0] MDU_MSUB  = 4'd8;
  localparam logic [3:0] MDU_MSUBU = 4'd9;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mduStateT;

endpackage

// File: rtl/mdu_pipelined_if.sv
// EX-stage request/result bundle between the pipeline (master) and the MDU (slave).
// Build option MDU_MADD_EN only widens the op decode; this bundle is unchanged.
interface mdu_pipelined_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);

endinterface

// File: rtl/mdu_latency_ctr.sv
// Loadable down-counter; done is high during the last cycle of a loaded latency.
// Used by mdu_pipelined (MDU_MADD_EN has no effect here).
module mdu_latency_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/mdu_pipelined.sv
// Multi-cycle multiply/divide unit with HI/LO; result is computed at start and committed after the latency.
// Build option: define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU (accumulate into {hi,lo}).
module mdu_pipelined
  import mdu_pipelined_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic          clk,
  input  logic          reset,
  mdu_pipelined_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mduStateT         state;
  logic             busyQ;
  logic [WIDTH-1:0] hiQ, loQ, pendHi, pendLo;

  logic [2*WIDTH-1:0] aSx, bSx, aZx, bZx, prodS, prodU;
  logic [WIDTH-1:0]   safeBS, safeBU, quotS, remS, quotU, remU;
  logic               divZero, divOvf;

  logic               isMulti, ctrLoad, ctrDone;
  logic [CNT_W-1:0]   latency;
  logic [WIDTH-1:0]   resHi, resLo;

  // Low 2*WIDTH bits of the extended products are the exact signed/unsigned products.
  assign aSx   = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign bSx   = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign aZx   = {{WIDTH{1'b0}}, bus.a};
  assign bZx   = {{WIDTH{1'b0}}, bus.b};
  assign prodS = aSx * bSx;
  assign prodU = aZx * bZx;

  // Forcing the divisor to 1 on overflow yields quotient=a, remainder=0 as required.
  assign divZero = (bus.b == '0);
  assign divOvf  = (bus.a == MOST_NEG) && (bus.b == '1);
  assign safeBS  = (divZero || divOvf) ? WIDTH'(1) : bus.b;
  assign safeBU  = divZero ? WIDTH'(1) : bus.b;
  assign quotS   = $signed(bus.a) / $signed(safeBS);
  assign remS    = $signed(bus.a) % $signed(safeBS);
  assign quotU   = bus.a / safeBU;
  assign remU    = bus.a % safeBU;

  always_comb begin
    // NOTE: every output gets a default first, so no decode path can infer a latch.
    isMulti = 1'b0;
    latency = '0;
    resHi   = '0;
    resLo   = '0;
    case (bus.op)
      MDU_MULT: begin
        isMulti        = 1'b1;
        latency        = MULT_LAT;
        {resHi, resLo} = prodS;
      end
      MDU_MULTU: begin
        isMulti        = 1'b1;
        latency        = MULT_LAT;
        {resHi, resLo} = prodU;
      end
      MDU_DIV: begin
        isMulti = 1'b1;
        latency = DIV_LAT;
        resHi   = divZero ? bus.a : remS;
        resLo   = divZero ? '1    : quotS;
      end
      MDU_DIVU: begin
        isMulti = 1'b1;
        latency = DIV_LAT;
        resHi   = divZero ? bus.a : remU;
        resLo   = divZero ? '1    : quotU;
      end
`ifdef MDU_MADD_EN
      MDU_MADD: begin
        isMulti        = 1'b1;
        latency        = MULT_LAT;
        {resHi, resLo} = {hiQ, loQ} + prodS;
      end
      MDU_MADDU: begin
        isMulti        = 1'b1;
        latency        = MULT_LAT;
        {resHi, resLo} = {hiQ, loQ} + prodU;
      end
      MDU_MSUB: begin
        isMulti        = 1'b1;
        latency        = MULT_LAT;
        {resHi, resLo} = {hiQ, loQ} - prodS;
      end
      MDU_MSUBU: begin
        isMulti        = 1'b1;
        latency        = MULT_LAT;
        {resHi, resLo} = {hiQ, loQ} - prodU;
      end
`endif
      default: ;
    endcase
  end

  assign ctrLoad = (state == MDU_IDLE) && bus.start && isMulti;

  mdu_latency_ctr #(.CNT_W(CNT_W)) u_latency_ctr (
    .clk    (clk),
    .reset  (reset),
    .load   (ctrLoad),
    .loadVal(latency),
    .done   (ctrDone)
  );

  // Requests arriving in RUN (including on the commit edge) are dropped; the hazard unit stalls instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MDU_IDLE;
      busyQ  <= 1'b0;
      hiQ    <= '0;
      loQ    <= '0;
      pendHi <= '0;
      pendLo <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (bus.start) begin
            if (isMulti) begin
              pendHi <= resHi;
              pendLo <= resLo;
              busyQ  <= 1'b1;
              state  <= MDU_RUN;
            end else if (bus.op == MDU_MTHI) begin
              hiQ <= bus.a;
            end else if (bus.op == MDU_MTLO) begin
              loQ <= bus.a;
            end
          end
        end
        MDU_RUN: begin
          if (ctrDone) begin
            hiQ   <= pendHi;
            loQ   <= pendLo;
            busyQ <= 1'b0;
            state <= MDU_IDLE;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  assign bus.busy = busyQ;
  assign bus.hi   = hiQ;
  assign bus.lo   = loQ;

endmodule
